// File: rtl/code_conv_seq_ctrl.sv
// code_conv_seq_ctrl: serial BCD <-> Excess-3 converter, one digit per cycle.
// Define CODE_CHECK_EN to build the per-digit code legality flags.
module code_conv_seq_ctrl #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [DIGITS*4-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIGITS*4-1:0] out_data,
    output logic                out_mode,
    output logic                out_err,
    output logic [DIGITS-1:0]   out_err_mask,
    output logic                busy
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       idx;
    logic [DIGITS*4-1:0] word;
    logic [DIGITS*4-1:0] result;
    logic                mode;
    logic [3:0]          din;
    logic [3:0]          dout;
    logic                last;
    logic                accept;

    assign accept = in_valid && in_ready;
    assign last   = (idx == IW'(DIGITS - 1));

    // the single shared digit unit
    assign din  = word[idx*4 +: 4];
    assign dout = mode ? (din - 4'd3) : (din + 4'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = CONV;
            CONV:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            word   <= '0;
            result <= '0;
            mode   <= 1'b0;
        end else if (accept) begin
            idx    <= '0;
            word   <= in_data;
            result <= '0;
            mode   <= in_mode;
        end else if (state == CONV) begin
            result[idx*4 +: 4] <= dout;
            if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef CODE_CHECK_EN
    logic              dig_bad;
    logic [DIGITS-1:0] mask;

    assign dig_bad = mode ? ((din < 4'd3) || (din > 4'd12))
                          : (din > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (accept) begin
            mask <= '0;
        end else if (state == CONV) begin
            mask[idx] <= dig_bad;
        end
    end

    assign out_err_mask = mask;
`else
    assign out_err_mask = '0;
`endif

    assign out_err   = |out_err_mask;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = result;
    assign out_mode  = mode;

endmodule
